fifo: RTL and testbench

FIFO -- requirements
Module: fifo

---
 rtl/fifo.sv | 58 +++++
 tb/tb_fifo.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fifo.sv
// First-word-fall-through FIFO: circular buffer with (BITDEPTH+1)-bit pointers,
// the extra MSB separating full from empty. Buffer contents are never reset.
module fifo #(
  parameter int BITWIDTH = 8,
  parameter int BITDEPTH = 2
) (
  input  logic                clk6x,
  input  logic                resetn,
  input  logic [BITWIDTH-1:0] wport_i,
  input  logic                wenq_i,
  output logic [BITWIDTH-1:0] rport_o,
  input  logic                rdeq_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [BITDEPTH:0]   count_o
);

  localparam int                DEPTH      = 2 ** BITDEPTH;
  localparam logic [BITDEPTH:0] FULL_COUNT = (BITDEPTH + 1)'(DEPTH);
  localparam logic [BITDEPTH:0] PTR_ONE    = (BITDEPTH + 1)'(1);

  logic [BITWIDTH-1:0] mem_q [DEPTH];
  logic [BITDEPTH:0]   wptr_q, wptr_d;
  logic [BITDEPTH:0]   rptr_q, rptr_d;
  logic                do_wr, do_rd;

  assign count_o = wptr_q - rptr_q;
  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == FULL_COUNT);
  assign rport_o = mem_q[rptr_q[BITDEPTH-1:0]];

  // A write while full is allowed only when the head is leaving on the same edge;
  // it then lands in the slot being vacated.
  assign do_wr = wenq_i && (!full_o || rdeq_i);
  assign do_rd = rdeq_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_wr) wptr_d = wptr_q + PTR_ONE;
    if (do_rd) rptr_d = rptr_q + PTR_ONE;
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk6x) begin
    if (do_wr) mem_q[wptr_q[BITDEPTH-1:0]] <= wport_i;
  end

endmodule

// File: tb/tb_fifo.sv
// Randomised and directed bench for fifo: the driver keeps a queue model of the
// expected contents; a negedge monitor checks flags, head data and dequeued words.
`timescale 1ns/1ps
module tb_fifo;

  localparam int W     = 8;
  localparam int D     = 2;
  localparam int DEPTH = 2 ** D;

  logic         clk6x = 1'b0;
  logic         resetn = 1'b0;
  logic [W-1:0] wport_i = '0;
  logic         wenq_i = 1'b0;
  logic [W-1:0] rport_o;
  logic         rdeq_i = 1'b0;
  logic         full_o;
  logic         empty_o;
  logic [D:0]   count_o;

  fifo #(.BITWIDTH(W), .BITDEPTH(D)) dut (
    .clk6x  (clk6x),
    .resetn (resetn),
    .wport_i(wport_i),
    .wenq_i (wenq_i),
    .rport_o(rport_o),
    .rdeq_i (rdeq_i),
    .full_o (full_o),
    .empty_o(empty_o),
    .count_o(count_o)
  );

  always #5 clk6x = ~clk6x;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  int           occ = 0;       // occupancy before the upcoming edge
  int           occ_next = 0;  // occupancy after the upcoming edge

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s t=%0t got=0x%0h want=0x%0h", name, $time, got, want);
    end
  endtask

  // One clock of stimulus; model decisions come from the queue occupancy alone.
  task automatic cycle(input logic w, input logic [W-1:0] d, input logic r);
    bit acc_w, acc_r;
    @(posedge clk6x); #1;
    occ = occ_next;
    wenq_i  = w;
    wport_i = d;
    rdeq_i  = r;
    acc_r = r && (occ > 0);
    acc_w = w && ((occ < DEPTH) || acc_r);
    if (acc_w) exp_q.push_back(d);
    occ_next = occ + int'(acc_w) - int'(acc_r);
    $display("cyc t=%0t wenq=%0d data=0x%02h rdeq=%0d occ=%0d", $time, w, d, r, occ);
  endtask

  always @(negedge clk6x) begin
    if (resetn === 1'b1) begin
      check("count", 32'(count_o), 32'(occ));
      check("empty", 32'(empty_o), 32'(occ == 0));
      check("full",  32'(full_o),  32'(occ == DEPTH));
      if (occ > 0) begin
        if (exp_q.size() == 0) begin
          check("model_underflow", 32'(exp_q.size()), 32'(1));
        end else if (rdeq_i) begin
          check("deq_data", 32'(rport_o), 32'(exp_q.pop_front()));
        end else begin
          check("head", 32'(rport_o), 32'(exp_q[0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    logic [W-1:0] seq [7];
    seq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE};

    // Reset held for 4 cycles, released between edges
    repeat (4) @(posedge clk6x);
    #1 resetn = 1'b1;
    #1;
    check("rst_count", 32'(count_o), 32'(0));
    check("rst_empty", 32'(empty_o), 32'(1));
    check("rst_full",  32'(full_o),  32'(0));

    // Fill to full, then drain with one extra ignored dequeue
    for (int i = 0; i < 4; i++) cycle(1'b1, seq[i], 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);

    // Overlapped enqueue/dequeue at count 2
    cycle(1'b1, seq[0], 1'b0);
    cycle(1'b1, seq[1], 1'b0);
    for (int i = 2; i < 7; i++) cycle(1'b1, seq[i], 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b1);

    // Full with simultaneous enqueue/dequeue, then drain
    for (int i = 0; i < 4; i++) cycle(1'b1, seq[i], 1'b0);
    for (int i = 4; i < 7; i++) cycle(1'b1, seq[i], 1'b1);
    cycle(1'b1, 8'hFF, 1'b0);                       // write while full: ignored
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);

    // Both strobes while empty: only the enqueue lands
    cycle(1'b1, 8'hA5, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Asynchronous reset mid-stream at count 3
    for (int i = 0; i < 3; i++) cycle(1'b1, seq[i], 1'b0);
    @(posedge clk6x); #1;
    occ = occ_next;
    wenq_i = 1'b0;
    rdeq_i = 1'b0;
    check("pre_rst_count", 32'(count_o), 32'(3));
    #2 resetn = 1'b0;
    exp_q.delete();
    occ = 0;
    occ_next = 0;
    #1;
    check("async_rst_count", 32'(count_o), 32'(0));
    check("async_rst_empty", 32'(empty_o), 32'(1));
    check("async_rst_full",  32'(full_o),  32'(0));
    @(posedge clk6x); #1 resetn = 1'b1;

    // Enqueue accepted on the first edge after release
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);

    // Random traffic with shifting write/read bias
    for (int ph = 0; ph < 8; ph++) begin
      int pw, pr;
      pw = $urandom_range(20, 90);
      pr = $urandom_range(20, 90);
      for (int k = 0; k < 50; k++) begin
        cycle(($urandom_range(99) < pw), W'($urandom), ($urandom_range(99) < pr));
      end
    end
    while (occ_next > 0) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
